core_dbg_apb_arbiter: RTL and testbench

- APB master front-end for the core debug APB slave.
- Accepts debug register access requests from NUM_REQ requesters (e.g. the JTAG DTM and the on-chip debug host) and arbitrates them round-robin.
- Sequences each granted request as one APB transfer (SETUP then ACCESS), honours `ready` wait states, and returns read data or a timeout error to the originating requester.

---
 rtl/core_dbg_apb_arbiter.sv | 176 +++++++++++++++++
 tb/tb_core_dbg_apb_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/core_dbg_apb_arbiter.sv
// Round-robin APB master front-end for the core debug APB slave.
// Each granted request becomes one SETUP/ACCESS transfer with a bounded wait-state timeout.
module core_dbg_apb_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int APB_ADDR_WIDTH = 5,
   parameter int APB_DATA_WIDTH = 32,
   parameter int TIMEOUT        = 15
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NUM_REQ-1:0]                  req,
   input  logic [NUM_REQ-1:0]                  req_wr,
   input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0]   req_addr,
   input  logic [NUM_REQ*APB_DATA_WIDTH-1:0]   req_wdata,
   input  logic [NUM_REQ*4-1:0]                req_wstrobe,
   output logic [NUM_REQ-1:0]                  gnt,
   output logic                                rsp_valid,
   output logic                                rsp_id,
   output logic [APB_DATA_WIDTH-1:0]           rsp_rdata,
   output logic                                rsp_err,
   output logic [APB_ADDR_WIDTH-1:0]           apb_addr,
   output logic                                apb_sel,
   output logic                                apb_enable,
   output logic                                apb_wr_rd,
   output logic [APB_DATA_WIDTH-1:0]           apb_wdata,
   output logic [3:0]                          apb_wstrobe,
   input  logic                                apb_ready,
   input  logic [APB_DATA_WIDTH-1:0]           apb_rdata
);

   localparam int AW    = APB_ADDR_WIDTH;
   localparam int DW    = APB_DATA_WIDTH;
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t            state_q, state_d;
   logic              last_q, last_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
   logic [AW-1:0]     apb_addr_q, apb_addr_d;
   logic              apb_sel_q, apb_sel_d;
   logic              apb_enable_q, apb_enable_d;
   logic              apb_wr_rd_q, apb_wr_rd_d;
   logic [DW-1:0]     apb_wdata_q, apb_wdata_d;
   logic [3:0]        apb_wstrobe_q, apb_wstrobe_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_id_q, rsp_id_d;
   logic [DW-1:0]     rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;

   logic              other_id;
   logic              win_id;
   logic              win_wr;
   logic [AW-1:0]     win_addr;
   logic [DW-1:0]     win_wdata;
   logic [3:0]        win_wstrobe;

   // The requester that was not served last gets priority; a lone requester always wins.
   always_comb begin
      other_id    = ~last_q;
      win_id      = req[other_id] ? other_id : last_q;
      win_wr      = req_wr[win_id];
      win_addr    = win_id ? req_addr[AW +: AW]   : req_addr[0 +: AW];
      win_wdata   = win_id ? req_wdata[DW +: DW]  : req_wdata[0 +: DW];
      win_wstrobe = win_id ? req_wstrobe[4 +: 4]  : req_wstrobe[0 +: 4];
      cnt_inc     = (cnt_q == CNT_W'(TIMEOUT)) ? cnt_q : cnt_q + CNT_W'(1);
   end

   always_comb begin
      state_d       = state_q;
      last_d        = last_q;
      cnt_d         = cnt_q;
      apb_addr_d    = apb_addr_q;
      apb_sel_d     = apb_sel_q;
      apb_enable_d  = apb_enable_q;
      apb_wr_rd_d   = apb_wr_rd_q;
      apb_wdata_d   = apb_wdata_q;
      apb_wstrobe_d = apb_wstrobe_q;
      rsp_valid_d   = 1'b0;
      rsp_id_d      = rsp_id_q;
      rsp_rdata_d   = '0;
      rsp_err_d     = 1'b0;
      gnt           = '0;

      case (state_q)
         IDLE: begin
            apb_sel_d    = 1'b0;
            apb_enable_d = 1'b0;
            if (|req) begin
               gnt[win_id]   = 1'b1;
               apb_sel_d     = 1'b1;
               apb_wr_rd_d   = win_wr;
               apb_addr_d    = win_addr;
               apb_wdata_d   = win_wr ? win_wdata : '0;
               apb_wstrobe_d = win_wr ? win_wstrobe : 4'h0;
               last_d        = win_id;
               rsp_id_d      = win_id;
               state_d       = SETUP;
            end
         end
         SETUP: begin
            apb_sel_d    = 1'b1;
            apb_enable_d = 1'b1;
            cnt_d        = '0;
            state_d      = ACCESS;
         end
         ACCESS: begin
            if (apb_ready) begin
               rsp_valid_d  = 1'b1;
               rsp_rdata_d  = apb_wr_rd_q ? '0 : apb_rdata;
               apb_sel_d    = 1'b0;
               apb_enable_d = 1'b0;
               state_d      = IDLE;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == CNT_W'(TIMEOUT)) begin
                  rsp_valid_d  = 1'b1;
                  rsp_err_d    = 1'b1;
                  apb_sel_d    = 1'b0;
                  apb_enable_d = 1'b0;
                  state_d      = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (rst) begin
         gnt = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         last_q        <= 1'b1;
         cnt_q         <= '0;
         apb_addr_q    <= '0;
         apb_sel_q     <= 1'b0;
         apb_enable_q  <= 1'b0;
         apb_wr_rd_q   <= 1'b0;
         apb_wdata_q   <= '0;
         apb_wstrobe_q <= 4'h0;
         rsp_valid_q   <= 1'b0;
         rsp_id_q      <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_q        <= last_d;
         cnt_q         <= cnt_d;
         apb_addr_q    <= apb_addr_d;
         apb_sel_q     <= apb_sel_d;
         apb_enable_q  <= apb_enable_d;
         apb_wr_rd_q   <= apb_wr_rd_d;
         apb_wdata_q   <= apb_wdata_d;
         apb_wstrobe_q <= apb_wstrobe_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_id_q      <= rsp_id_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
      end
   end

   assign apb_addr    = apb_addr_q;
   assign apb_sel     = apb_sel_q;
   assign apb_enable  = apb_enable_q;
   assign apb_wr_rd   = apb_wr_rd_q;
   assign apb_wdata   = apb_wdata_q;
   assign apb_wstrobe = apb_wstrobe_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_id      = rsp_id_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_core_dbg_apb_arbiter.sv
// Self-checking bench for core_dbg_apb_arbiter: cycle-level protocol checks plus a response scoreboard.
module tb_core_dbg_apb_arbiter;

   localparam int NUM_REQ = 2;
   localparam int AW      = 5;
   localparam int DW      = 32;
   localparam int TIMEOUT = 15;

   logic                  clk;
   logic                  rst;
   logic [NUM_REQ-1:0]    req;
   logic [NUM_REQ-1:0]    req_wr;
   logic [NUM_REQ*AW-1:0] req_addr;
   logic [NUM_REQ*DW-1:0] req_wdata;
   logic [NUM_REQ*4-1:0]  req_wstrobe;
   logic [NUM_REQ-1:0]    gnt;
   logic                  rsp_valid;
   logic                  rsp_id;
   logic [DW-1:0]         rsp_rdata;
   logic                  rsp_err;
   logic [AW-1:0]         apb_addr;
   logic                  apb_sel;
   logic                  apb_enable;
   logic                  apb_wr_rd;
   logic [DW-1:0]         apb_wdata;
   logic [3:0]            apb_wstrobe;
   logic                  apb_ready;
   logic [DW-1:0]         apb_rdata;

   int n_checks;
   int n_errors;

   // Expected response word: {rsp_id, rsp_err, rsp_rdata}
   logic [DW+1:0] exp_q[$];

   core_dbg_apb_arbiter #(
      .NUM_REQ(NUM_REQ), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_wstrobe(req_wstrobe), .gnt(gnt),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .apb_addr(apb_addr), .apb_sel(apb_sel), .apb_enable(apb_enable), .apb_wr_rd(apb_wr_rd),
      .apb_wdata(apb_wdata), .apb_wstrobe(apb_wstrobe), .apb_ready(apb_ready), .apb_rdata(apb_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   // Scoreboard: every response pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && rsp_valid) begin
         if (exp_q.size() == 0) begin
            check("rsp_unexpected", 64'd1, 64'd0);
         end else begin
            check("rsp", {30'd0, rsp_id, rsp_err, rsp_rdata}, {30'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic set_req(input int id, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [3:0] wstrb);
      req_wr[id]              = wr;
      req_addr[id*AW +: AW]   = addr;
      req_wdata[id*DW +: DW]  = wdata;
      req_wstrobe[id*4 +: 4]  = wstrb;
   endtask

   // One isolated access; waits >= TIMEOUT holds ready low until the timeout abort.
   task automatic do_access(input int id, input logic wr, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input logic [3:0] wstrb,
                            input int waits, input logic [DW-1:0] rdata);
      logic          tmo;
      logic [DW-1:0] exp_data;
      logic [3:0]    exp_strb;
      logic [NUM_REQ-1:0] exp_gnt;
      tmo      = (waits >= TIMEOUT);
      exp_data = (wr || tmo) ? '0 : rdata;
      exp_strb = wr ? wstrb : 4'h0;
      exp_gnt  = (id == 0) ? 2'b01 : 2'b10;
      @(posedge clk); #1;
      set_req(id, wr, addr, wdata, wstrb);
      req[id] = 1'b1;
      exp_q.push_back({id[0], tmo, exp_data});
      @(negedge clk);
      check("grant", {62'd0, gnt}, {62'd0, exp_gnt});
      check("idle_ctl", {62'd0, apb_sel, apb_enable}, 64'd0);
      @(posedge clk); #1;
      req[id] = 1'b0;
      @(negedge clk);
      check("setup_ctl", {62'd0, apb_sel, apb_enable}, 64'h2);
      check("setup_addr", {59'd0, apb_addr}, {59'd0, addr});
      check("setup_dir", {63'd0, apb_wr_rd}, {63'd0, wr});
      check("setup_wdata", {32'd0, apb_wdata}, {32'd0, wr ? wdata : 32'd0});
      check("setup_strb", {60'd0, apb_wstrobe}, {60'd0, exp_strb});
      for (int k = 0; k < TIMEOUT; k++) begin
         @(posedge clk); #1;
         apb_ready = (k == waits);
         apb_rdata = (k == waits) ? rdata : $urandom;
         @(negedge clk);
         check("access_ctl", {62'd0, apb_sel, apb_enable}, 64'h3);
         check("access_addr", {59'd0, apb_addr}, {59'd0, addr});
         check("access_strb", {60'd0, apb_wstrobe}, {60'd0, exp_strb});
         check("access_no_rsp", {63'd0, rsp_valid}, 64'd0);
         if (k == waits) break;
      end
      @(posedge clk); #1;
      apb_ready = 1'b0;
      @(negedge clk);
      check("rsp_pulse", {63'd0, rsp_valid}, 64'd1);
      check("end_ctl", {62'd0, apb_sel, apb_enable}, 64'd0);
   endtask

   initial begin
      logic [NUM_REQ-1:0] exp_gnt;
      n_checks    = 0;
      n_errors    = 0;
      rst         = 1'b1;
      req         = '0;
      req_wr      = '0;
      req_addr    = '0;
      req_wdata   = '0;
      req_wstrobe = '0;
      apb_ready   = 1'b0;
      apb_rdata   = '0;

      // Reset values, and no grant while reset is held even with requests pending
      @(posedge clk); #1;
      req = 2'b11;
      @(posedge clk);
      @(negedge clk);
      check("rst_gnt", {62'd0, gnt}, 64'd0);
      check("rst_ctl", {62'd0, apb_sel, apb_enable}, 64'd0);
      check("rst_rsp", {63'd0, rsp_valid}, 64'd0);
      check("rst_apb", {AW + DW + 4 + 1{1'b0}} == {apb_addr, apb_wdata, apb_wstrobe, apb_wr_rd}, 64'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      req = 2'b00;

      // Zero-wait write, 3-wait read, timeout, recovery, ready on the last allowed cycle
      do_access(0, 1'b1, 5'h04, 32'hDEADBEEF, 4'hF, 0, 32'h0);
      do_access(1, 1'b0, 5'h10, 32'hFFFF0000, 4'hA, 3, 32'h12345678);
      do_access(0, 1'b0, 5'h08, 32'h0, 4'h0, TIMEOUT, 32'h0BADF00D);
      do_access(1, 1'b1, 5'h1C, 32'h5A5A5A5A, 4'h3, 1, 32'h0);
      do_access(0, 1'b0, 5'h0C, 32'h0, 4'h0, TIMEOUT - 1, 32'hA5A51234);

      // Reset during an ACCESS wait state: no response may come out for that access
      @(posedge clk); #1;
      set_req(0, 1'b0, 5'h02, 32'h0, 4'h0);
      req[0] = 1'b1;
      @(posedge clk); #1;
      req[0] = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      rst       = 1'b1;
      req       = 2'b11;
      apb_ready = 1'b1;
      apb_rdata = 32'hCAFE0001;
      set_req(0, 1'b1, 5'h01, 32'h11112222, 4'h5);
      set_req(1, 1'b0, 5'h1F, 32'h0, 4'h0);
      @(negedge clk);
      check("midrst_gnt", {62'd0, gnt}, 64'd0);
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back((i % 2 == 0) ? {1'b0, 1'b0, 32'h0} : {1'b1, 1'b0, 32'hCAFE0001});
      end
      @(posedge clk); #1;
      rst = 1'b0;

      // Contention straight out of reset: 0,1,0,1 at 3-cycle spacing
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (c == 0) begin
            check("postrst_rsp", {63'd0, rsp_valid}, 64'd0);
         end
         if (c % 3 == 0) begin
            exp_gnt = ((c / 3) % 2 == 1) ? 2'b10 : 2'b01;
            check("cont_gnt", {62'd0, gnt}, {62'd0, exp_gnt});
            check("cont_idle_ctl", {62'd0, apb_sel, apb_enable}, 64'd0);
         end else begin
            check("cont_busy_gnt", {62'd0, gnt}, 64'd0);
            check("cont_ctl", {62'd0, apb_sel, apb_enable}, (c % 3 == 1) ? 64'h2 : 64'h3);
         end
         @(posedge clk); #1;
      end
      req       = 2'b00;
      apb_ready = 1'b0;
      @(negedge clk);
      check("cont_last_rsp", {63'd0, rsp_valid}, 64'd1);

      // Randomised isolated accesses
      for (int n = 0; n < 8; n++) begin
         do_access($urandom_range(0, 1), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                   $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 4), $urandom);
      end

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
